pipe_status_ctrl: RTL and testbench

//  Parametrised CPU run/stall/pipeline-reset controller for an NSTG-stage pipeline.

---
 rtl/pipe_status_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_status_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_status_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_status_ctrl
// Run/stall/pipeline-reset controller for an NSTG-stage CPU pipeline.
// Merges the stall sources, waits for DRAM calibration, sequences start/quit
// and provides a single-/multi-step debug mode. Stall and flush are fanned out
// to the pipeline stages with a per-stage stagger.
//
// Optional feature macro: STALL_CNT_EN
//   defined   : stall_cycles counts cycles with cpu_running & stall
//               (saturating, cleared while rst_pipe is high)
//   undefined : stall_cycles tied to 0, no counter flops
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   stall_src            stall requests from NSRC sources (OR-reduced)
//   init_calib_complete  memory calibration done
//   cpu_start            start pulse
//   quit_cmd             stop pulse
//   step_cmd             step request pulse
//   step_num             cycles to step, sampled with step_cmd (0 acts as 1)
//   stall                global fetch stall
//   stall_stg            per-stage stall, index 0 = ID ... NSTG-1 = WB
//   stall_1shot          first cycle of a stall
//   stall_dly            stall delayed by one cycle
//   rst_pipe             pipeline flush pulse for the fetch stage
//   rst_pipe_stg         flush pulse, stage k delayed by k+1 cycles
//   cpu_running          state RUN or STEP
//   step_busy            state STEP
//   stall_cycles         stalled-while-running cycle count
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_status_ctrl #(
    parameter int unsigned NSTG   = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   stall_src,
    input  logic              init_calib_complete,
    input  logic              cpu_start,
    input  logic              quit_cmd,
    input  logic              step_cmd,
    input  logic [STEP_W-1:0] step_num,
    output logic              stall,
    output logic [NSTG-1:0]   stall_stg,
    output logic              stall_1shot,
    output logic              stall_dly,
    output logic              rst_pipe,
    output logic [NSTG-1:0]   rst_pipe_stg,
    output logic              cpu_running,
    output logic              step_busy,
    output logic [31:0]       stall_cycles
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_cnt_nxt;
    logic              src_any;
    logic              rst_pipe_nxt;
    // Stall history: dly[k] is stall delayed by k cycles.
    logic [NSTG-1:1]   dly;

    assign src_any = |stall_src;

    // State and step counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
        end
    end

    // Next-state logic; priority quit > lost calibration > start > step
    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        if (quit_cmd) begin
            state_nxt = S_IDLE;
        end else if (!init_calib_complete) begin
            // PEND holds here until calibration finishes
            case (state)
                S_RUN, S_STEP: state_nxt = S_IDLE;
                S_IDLE:        if (cpu_start) state_nxt = S_PEND;
                default:       state_nxt = state;
            endcase
        end else if (cpu_start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE: begin
                    if (step_cmd) begin
                        state_nxt    = S_STEP;
                        step_cnt_nxt = (step_num == '0) ? STEP_W'(1) : step_num;
                    end
                end
                S_PEND: state_nxt = S_RUN;
                S_STEP: begin
                    // Stalled cycles do not consume step credit
                    if (!src_any) begin
                        step_cnt_nxt = step_cnt - STEP_W'(1);
                        if (step_cnt == STEP_W'(1)) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Registered state decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_running <= 1'b0;
            step_busy   <= 1'b0;
        end else begin
            cpu_running <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
            step_busy   <= (state_nxt == S_STEP);
        end
    end

    // Flush on a real start or a real stop; commands that do not change
    // the running status (start while stepping, quit while idle) do not flush
    assign rst_pipe_nxt = (cpu_start & ~cpu_running) | (quit_cmd & cpu_running);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe     <= 1'b0;
            rst_pipe_stg <= '0;
        end else begin
            rst_pipe        <= rst_pipe_nxt;
            rst_pipe_stg[0] <= rst_pipe;
            for (int k = 1; k < int'(NSTG); k++) begin
                rst_pipe_stg[k] <= rst_pipe_stg[k-1];
            end
        end
    end

    // Fetch stall goes out in the same cycle as the source request
    assign stall       = ~cpu_running | src_any;
    assign stall_dly   = dly[1];
    assign stall_1shot = stall & ~dly[1];

    // Stall history shift register; resets to "stalled" everywhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '1;
        end else begin
            dly[1] <= stall;
            for (int k = 2; k < int'(NSTG); k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    // Stage k stays stalled only while stall has been high for k more cycles,
    // so a released stall drains down the pipe one stage per cycle
    always_comb begin
        logic acc;
        acc          = stall;
        stall_stg    = '0;
        stall_stg[0] = acc;
        for (int k = 1; k < int'(NSTG); k++) begin
            acc          = acc & dly[k];
            stall_stg[k] = acc;
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating stall counter, cleared by the flush pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (rst_pipe) begin
            stall_cnt <= '0;
        end else if (cpu_running && stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_status_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_status_ctrl
// Self-checking bench for pipe_status_ctrl: a behavioural reference model
// produces the expected outputs for every cycle into a scoreboard queue,
// plus directed checks of the start, pending, stall, step, quit and reset
// scenarios. Honours STALL_CNT_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_status_ctrl;

    localparam int NSTG   = 5;
    localparam int NSRC   = 2;
    localparam int STEP_W = 16;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;

    logic              clk;
    logic              rst_n;
    logic [NSRC-1:0]   stall_src;
    logic              init_calib_complete;
    logic              cpu_start;
    logic              quit_cmd;
    logic              step_cmd;
    logic [STEP_W-1:0] step_num;
    logic              stall;
    logic [NSTG-1:0]   stall_stg;
    logic              stall_1shot;
    logic              stall_dly;
    logic              rst_pipe;
    logic [NSTG-1:0]   rst_pipe_stg;
    logic              cpu_running;
    logic              step_busy;
    logic [31:0]       stall_cycles;

    pipe_status_ctrl #(.NSTG(NSTG), .NSRC(NSRC), .STEP_W(STEP_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stall_src           (stall_src),
        .init_calib_complete (init_calib_complete),
        .cpu_start           (cpu_start),
        .quit_cmd            (quit_cmd),
        .step_cmd            (step_cmd),
        .step_num            (step_num),
        .stall               (stall),
        .stall_stg           (stall_stg),
        .stall_1shot         (stall_1shot),
        .stall_dly           (stall_dly),
        .rst_pipe            (rst_pipe),
        .rst_pipe_stg        (rst_pipe_stg),
        .cpu_running         (cpu_running),
        .step_busy           (step_busy),
        .stall_cycles        (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            stall;
        logic [NSTG-1:0] stg;
        logic            shot;
        logic            dly;
        logic            rp;
        logic [NSTG-1:0] rps;
        logic            run;
        logic            busy;
        logic [31:0]     cyc;
    } outs_t;

    outs_t obs;
    outs_t sb_q[$];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int              m_st;
    int unsigned     m_cnt;
    logic [NSTG-1:1] m_hist;
    logic            m_rp;
    logic [NSTG-1:0] m_rps;
    logic [31:0]     m_sc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_cnt  = 0;
        m_hist = '1;
        m_rp   = 1'b0;
        m_rps  = '0;
        m_sc   = 32'h0;
    endtask

    // Expected outputs for the current model state and current inputs
    task automatic model_exp(output outs_t e);
        logic run;
        logic all_prev;
        run      = (m_st == M_RUN) || (m_st == M_STEP);
        e        = '0;
        e.stall  = !run || (stall_src != '0);
        all_prev = 1'b1;
        for (int k = 0; k < NSTG; k++) begin
            if (k > 0) all_prev = all_prev && m_hist[k];
            e.stg[k] = e.stall && all_prev;
        end
        e.shot = e.stall && !m_hist[1];
        e.dly  = m_hist[1];
        e.rp   = m_rp;
        e.rps  = m_rps;
        e.run  = run;
        e.busy = (m_st == M_STEP);
        e.cyc  = m_sc;
    endtask

    // Advance the model across one rising edge
    task automatic model_clock();
        logic run;
        logic stall_now;
        logic any_src;
        run       = (m_st == M_RUN) || (m_st == M_STEP);
        any_src   = (stall_src != '0);
        stall_now = !run || any_src;
`ifdef STALL_CNT_EN
        if (m_rp) m_sc = 32'h0;
        else if (run && stall_now && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
`endif
        for (int k = NSTG - 1; k >= 1; k--) begin
            m_rps[k] = m_rps[k-1];
        end
        m_rps[0] = m_rp;
        m_rp     = (cpu_start && !run) || (quit_cmd && run);
        for (int k = NSTG - 1; k >= 2; k--) begin
            m_hist[k] = m_hist[k-1];
        end
        m_hist[1] = stall_now;
        if (quit_cmd) begin
            m_st = M_IDLE;
        end else if (!init_calib_complete) begin
            if (run) m_st = M_IDLE;
            else if (m_st == M_IDLE && cpu_start) m_st = M_PEND;
        end else if (cpu_start) begin
            m_st = M_RUN;
        end else if (m_st == M_IDLE && step_cmd) begin
            m_cnt = (step_num == '0) ? 1 : int'(step_num);
            m_st  = M_STEP;
        end else if (m_st == M_PEND) begin
            m_st = M_RUN;
        end else if (m_st == M_STEP && !any_src) begin
            if (m_cnt == 1) m_st = M_IDLE;
            m_cnt = m_cnt - 1;
        end
    endtask

    // One clock: drive at the falling edge, push the expectation, sample,
    // compare, then step the model with the rising edge
    task automatic cycle(input logic [1:0] src, input logic cal, input logic st,
                         input logic qt, input logic sp, input logic [15:0] num);
        outs_t e;
        outs_t x;
        stall_src           = src;
        init_calib_complete = cal;
        cpu_start           = st;
        quit_cmd            = qt;
        step_cmd            = sp;
        step_num            = num;
        model_exp(e);
        sb_q.push_back(e);
        #1;
        obs.stall = stall;
        obs.stg   = stall_stg;
        obs.shot  = stall_1shot;
        obs.dly   = stall_dly;
        obs.rp    = rst_pipe;
        obs.rps   = rst_pipe_stg;
        obs.run   = cpu_running;
        obs.busy  = step_busy;
        obs.cyc   = stall_cycles;
        x = sb_q.pop_front();
        chk("stall",        32'(obs.stall), 32'(x.stall));
        chk("stall_stg",    32'(obs.stg),   32'(x.stg));
        chk("stall_1shot",  32'(obs.shot),  32'(x.shot));
        chk("stall_dly",    32'(obs.dly),   32'(x.dly));
        chk("rst_pipe",     32'(obs.rp),    32'(x.rp));
        chk("rst_pipe_stg", 32'(obs.rps),   32'(x.rps));
        chk("cpu_running",  32'(obs.run),   32'(x.run));
        chk("step_busy",    32'(obs.busy),  32'(x.busy));
        chk("stall_cycles", obs.cyc,        x.cyc);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic cal);
        for (int i = 0; i < n; i++) cycle(2'b00, cal, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_running"}, 32'(cpu_running),  0);
        chk({tag, "_busy"},    32'(step_busy),    0);
        chk({tag, "_stall"},   32'(stall),        1);
        chk({tag, "_dly"},     32'(stall_dly),    1);
        chk({tag, "_1shot"},   32'(stall_1shot),  0);
        chk({tag, "_stg"},     32'(stall_stg),    32'h1F);
        chk({tag, "_rp"},      32'(rst_pipe),     0);
        chk({tag, "_rps"},     32'(rst_pipe_stg), 0);
        chk({tag, "_cycles"},  stall_cycles,      0);
    endtask

    int n_a;
    int n_b;
    int n_c;
    int exp_cnt;

    initial begin
        stall_src           = '0;
        init_calib_complete = 1'b0;
        cpu_start           = 1'b0;
        quit_cmd            = 1'b0;
        step_cmd            = 1'b0;
        step_num            = '0;
        rst_n               = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        reset_checks("rst0");
        rst_n = 1'b1;

        // Start with calibration done
        idle_cycles(1, 1'b1);
        cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("t1_running", 32'(cpu_running), 1);
        chk("t1_rst_pipe", 32'(rst_pipe), 1);
        chk("t1_stall", 32'(stall), 0);
        idle_cycles(5, 1'b1);
        chk("t1_rps4", 32'(rst_pipe_stg[4]), 1);
        chk("t1_rps3", 32'(rst_pipe_stg[3]), 0);

        // Three-cycle stall from source 0 while running
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 8; i++) begin
            cycle((i < 3) ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
            n_a += int'(obs.stall);
            n_b += int'(obs.shot);
            n_c += int'(obs.stg[2]);
        end
        chk("t3_stall_len", n_a, 3);
        chk("t3_1shot_len", n_b, 1);
        chk("t3_stg2_len", n_c, 1);

        // Quit, then start without calibration -> PEND
        cycle(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        chk("t2_quit_idle", 32'(cpu_running), 0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        n_a = 0; n_b = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            n_a += int'(obs.rp);
            n_b += int'(obs.stall);
        end
        chk("t2_rp_pulses", n_a, 1);
        chk("t2_stall_pend", n_b, 4);
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("t2_pre_run", 32'(obs.run), 0);
        chk("t2_running", 32'(cpu_running), 1);
        chk("t2_no_rp", 32'(rst_pipe), 0);

        // Step 4 with two stalled cycles in the middle
        cycle(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        idle_cycles(2, 1'b1);
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4);
        n_a = 0; n_b = 0;
        for (int i = 0; i < 12; i++) begin
            cycle((i == 1 || i == 2) ? 2'b10 : 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
            n_a += int'(obs.busy);
            n_b += int'(obs.rp);
        end
        chk("t4_busy_len", n_a, 6);
        chk("t4_no_rp", n_b, 0);
        chk("t4_idle", 32'(cpu_running), 0);

        // step_num of zero behaves as one
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        n_a = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
            n_a += int'(obs.busy);
        end
        chk("t4_step0_len", n_a, 1);

        // Start and quit together while running
        cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        idle_cycles(3, 1'b1);
        cycle(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
        chk("t5_idle", 32'(cpu_running), 0);
        n_a = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
            n_a += int'(obs.rp);
        end
        chk("t5_rp_pulses", n_a, 1);

        // Asynchronous reset in the middle of a step
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10);
        idle_cycles(3, 1'b1);
        chk("t5_busy_pre", 32'(step_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("rst1");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Stall counter: ten stalled running cycles, held in IDLE, cleared by start
        cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        idle_cycles(1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
`ifdef STALL_CNT_EN
        exp_cnt = 10;
`else
        exp_cnt = 0;
`endif
        chk("t6_cycles10", stall_cycles, 32'(exp_cnt));
        idle_cycles(1, 1'b0);
        chk("t6_calib_idle", 32'(cpu_running), 0);
        idle_cycles(2, 1'b1);
        chk("t6_hold", stall_cycles, 32'(exp_cnt));
        cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        idle_cycles(1, 1'b1);
        chk("t6_cleared", stall_cycles, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom_range(0, 11) != 0,
                  $urandom_range(0, 13) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 5) == 0,
                  16'($urandom_range(0, 6)));
        end

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
